// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register. Holds the program
// counter and drives the instruction-memory address. The word that follows an
// immediate-carrying opcode is tagged so decode never treats it as an opcode.
// Taken branches redirect the PC and insert a plain bubble. An accepted
// external interrupt inserts a marked bubble that carries the return address.
//
// Ports
//   clk               in   clock, rising-edge
//   reset             in   asynchronous, active-low reset
//   stall             in   hazard hold (PC, state, IF/ID frozen)
//   branch_taken      in   redirect request from a later stage
//   branch_target     in   redirect address
//   interrupt         in   external interrupt line (rising edge = request)
//   imem_data         in   instruction word at imem_addr (same cycle)
//   imem_addr         out  current PC
//   if_id_instruction out  latched word
//   if_id_pc_plus1    out  address after latched word / interrupt return addr
//   if_id_valid       out  slot holds a real word or an interrupt bubble
//   if_id_is_imm      out  latched word is immediate data
//   if_id_interrupt   out  slot is an interrupt bubble
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                    PC_WIDTH        = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR    = '0,
  parameter logic [PC_WIDTH-1:0]   INT_VECTOR      = PC_WIDTH'(1),
  parameter logic [15:0]           IMM_OPCODE_MASK = 16'h0C00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                interrupt,
  input  logic [15:0]         imem_data,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [15:0]         if_id_instruction,
  output logic [PC_WIDTH-1:0] if_id_pc_plus1,
  output logic                if_id_valid,
  output logic                if_id_is_imm,
  output logic                if_id_interrupt
);

  // NORMAL: next fetched word is an opcode. IMM_WAIT: next word is immediate.
  typedef enum logic {
    NORMAL   = 1'b0,
    IMM_WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                int_q, int_q_d;
  logic                int_pend_q, int_pend_d;
  logic [15:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pcp1_q, pcp1_d;
  logic                valid_q, valid_d;
  logic                is_imm_q, is_imm_d;
  logic                intr_q, intr_d;

  logic                int_rise;
  logic                opcode_has_imm;
  logic [PC_WIDTH-1:0] pc_inc;

  assign int_rise       = interrupt & ~int_q;
  assign opcode_has_imm = IMM_OPCODE_MASK[imem_data[15:12]];
  // Wraps modulo 2^PC_WIDTH by construction.
  assign pc_inc         = pc_q + PC_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pcp1_d     = pcp1_q;
    valid_d    = valid_q;
    is_imm_d   = is_imm_q;
    intr_d     = intr_q;
    // The edge detector keeps sampling and new requests are latched even
    // while stalled or redirecting; repeated edges simply merge.
    int_q_d    = interrupt;
    int_pend_d = int_pend_q | int_rise;

    if (branch_taken) begin
      // Redirect wins over stall: the target must be fetched next cycle.
      pc_d     = branch_target;
      state_d  = NORMAL;
      instr_d  = 16'h0000;
      pcp1_d   = '0;
      valid_d  = 1'b0;
      is_imm_d = 1'b0;
      intr_d   = 1'b0;
    end else if (stall) begin
      // Hold everything; only the interrupt capture above advances.
    end else if (int_pend_q && (state_q == NORMAL)) begin
      // The word at PC is not consumed, so PC itself is the return address.
      instr_d    = 16'h0000;
      pcp1_d     = pc_q;
      valid_d    = 1'b1;
      is_imm_d   = 1'b0;
      intr_d     = 1'b1;
      pc_d       = INT_VECTOR;
      int_pend_d = int_rise;
    end else begin
      instr_d  = imem_data;
      pcp1_d   = pc_inc;
      valid_d  = 1'b1;
      intr_d   = 1'b0;
      pc_d     = pc_inc;
      if (state_q == IMM_WAIT) begin
        // Immediate data: never decoded as an opcode.
        is_imm_d = 1'b1;
        state_d  = NORMAL;
      end else begin
        is_imm_d = 1'b0;
        state_d  = opcode_has_imm ? IMM_WAIT : NORMAL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= NORMAL;
      pc_q       <= RESET_VECTOR;
      int_q      <= 1'b0;
      int_pend_q <= 1'b0;
      instr_q    <= 16'h0000;
      pcp1_q     <= '0;
      valid_q    <= 1'b0;
      is_imm_q   <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      int_q      <= int_q_d;
      int_pend_q <= int_pend_d;
      instr_q    <= instr_d;
      pcp1_q     <= pcp1_d;
      valid_q    <= valid_d;
      is_imm_q   <= is_imm_d;
      intr_q     <= intr_d;
    end
  end

  assign imem_addr         = pc_q;
  assign if_id_instruction = instr_q;
  assign if_id_pc_plus1    = pcp1_q;
  assign if_id_valid       = valid_q;
  assign if_id_is_imm      = is_imm_q;
  assign if_id_interrupt   = intr_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        interrupt;
  logic [15:0] imem_data;
  logic [31:0] imem_addr;
  logic [15:0] if_id_instruction;
  logic [31:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic        if_id_is_imm;
  logic        if_id_interrupt;

  logic [15:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(
    .PC_WIDTH(32),
    .RESET_VECTOR(32'd0),
    .INT_VECTOR(32'd1),
    .IMM_OPCODE_MASK(16'h0C00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .interrupt(interrupt),
    .imem_data(imem_data),
    .imem_addr(imem_addr),
    .if_id_instruction(if_id_instruction),
    .if_id_pc_plus1(if_id_pc_plus1),
    .if_id_valid(if_id_valid),
    .if_id_is_imm(if_id_is_imm),
    .if_id_interrupt(if_id_interrupt)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:0]];

  // Reference model: fetch pipeline described as "what does the next slot
  // contain", using integers and a boolean for "next word is immediate".
  int unsigned m_pc       = 0;
  bit          m_next_imm = 0;
  bit          m_pending  = 0;
  bit          m_line_old = 0;
  logic [15:0] e_instr    = 0;
  int unsigned e_pcp1     = 0;
  bit          e_valid    = 0;
  bit          e_imm      = 0;
  bit          e_intr     = 0;

  function automatic bit has_imm(input logic [15:0] w);
    int op;
    op = int'(w[15:12]);
    return (op == 10) || (op == 11);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 0; m_next_imm = 0; m_pending = 0; m_line_old = 0;
      e_instr = 0; e_pcp1 = 0; e_valid = 0; e_imm = 0; e_intr = 0;
    end else begin
      bit new_req;
      logic [15:0] w;
      new_req    = interrupt && !m_line_old;
      m_line_old = interrupt;
      if (branch_taken) begin
        m_pc = branch_target; m_next_imm = 0;
        e_instr = 0; e_pcp1 = 0; e_valid = 0; e_imm = 0; e_intr = 0;
        m_pending = m_pending || new_req;
      end else if (stall) begin
        m_pending = m_pending || new_req;
      end else if (m_pending && !m_next_imm) begin
        e_instr = 0; e_pcp1 = m_pc; e_valid = 1; e_imm = 0; e_intr = 1;
        m_pc = 1;
        m_pending = new_req;
      end else begin
        w = mem[m_pc % 256];
        e_instr = w; e_pcp1 = m_pc + 1; e_valid = 1; e_intr = 0;
        e_imm = m_next_imm;
        m_next_imm = m_next_imm ? 1'b0 : has_imm(w);
        m_pc = m_pc + 1;
        m_pending = m_pending || new_req;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT against model.
  always @(negedge clk) begin
    chk("model imem_addr",   imem_addr,                m_pc);
    chk("model instruction", {16'h0, if_id_instruction}, {16'h0, e_instr});
    chk("model pc_plus1",    if_id_pc_plus1,           e_pcp1);
    chk("model valid",       {31'h0, if_id_valid},     {31'h0, e_valid});
    chk("model is_imm",      {31'h0, if_id_is_imm},    {31'h0, e_imm});
    chk("model interrupt",   {31'h0, if_id_interrupt}, {31'h0, e_intr});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]    = 16'h1240; mem[1]    = 16'h5000; mem[2] = 16'h0003;
    mem[3]    = 16'h0004; mem[4]    = 16'h0005; mem[5] = 16'h0777;
    mem[6]    = 16'hA200; mem[7]    = 16'hA200; mem[8] = 16'h0100;
    mem[8'h40] = 16'h0440; mem[8'h41] = 16'hB000; mem[8'h42] = 16'h0442;
    mem[8'h50] = 16'h0550; mem[8'h51] = 16'hA123; mem[8'h52] = 16'h1111;
    mem[8'h53] = 16'h2222;
    mem[8'h60] = 16'hA000; mem[8'h61] = 16'h3333; mem[8'h62] = 16'h4444;

    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; interrupt = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst instr", {16'h0, if_id_instruction}, 32'h0);
    chk("rst addr",  imem_addr, 32'h0);
    reset = 1'b1;

    tick();
    chk("first instr", {16'h0, if_id_instruction}, 32'h1240);
    chk("first pcp1",  if_id_pc_plus1, 32'd1);
    tick();
    chk("second instr", {16'h0, if_id_instruction}, 32'h5000);
    chk("second pcp1",  if_id_pc_plus1, 32'd2);
    chk("second valid", {31'h0, if_id_valid}, 32'd1);

    // Stall at PC=5
    tick(); tick(); tick();
    chk("pre-stall addr", imem_addr, 32'd5);
    stall = 1'b1;
    tick(); tick(); tick();
    chk("stall addr",  imem_addr, 32'd5);
    chk("stall instr", {16'h0, if_id_instruction}, 32'h0005);
    stall = 1'b0;
    tick();
    chk("resume instr", {16'h0, if_id_instruction}, 32'h0777);
    chk("resume pcp1",  if_id_pc_plus1, 32'd6);

    // Immediate pair
    tick();
    chk("imm op instr",  {16'h0, if_id_instruction}, 32'hA200);
    chk("imm op is_imm", {31'h0, if_id_is_imm}, 32'd0);
    tick();
    chk("imm data instr",  {16'h0, if_id_instruction}, 32'hA200);
    chk("imm data is_imm", {31'h0, if_id_is_imm}, 32'd1);
    tick();
    chk("after pair is_imm", {31'h0, if_id_is_imm}, 32'd0);
    chk("after pair instr",  {16'h0, if_id_instruction}, 32'h0100);

    // Branch while stalled
    branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
    tick();
    chk("br bubble valid", {31'h0, if_id_valid}, 32'd0);
    chk("br addr",         imem_addr, 32'h40);
    branch_taken = 1'b0; stall = 1'b0;
    tick();
    chk("br target instr", {16'h0, if_id_instruction}, 32'h0440);
    chk("br target pcp1",  if_id_pc_plus1, 32'h41);

    // Branch taken while in IMM_WAIT
    tick();
    chk("B opcode instr", {16'h0, if_id_instruction}, 32'hB000);
    branch_taken = 1'b1; branch_target = 32'h50;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("br imm_wait instr",  {16'h0, if_id_instruction}, 32'h0550);
    chk("br imm_wait is_imm", {31'h0, if_id_is_imm}, 32'd0);

    // Interrupt rises while 0xA123 is being fetched
    interrupt = 1'b1;
    tick();
    chk("int defer op", {16'h0, if_id_instruction}, 32'hA123);
    tick();
    chk("int defer imm",   {31'h0, if_id_is_imm}, 32'd1);
    chk("int defer data",  {16'h0, if_id_instruction}, 32'h1111);
    tick();
    chk("int bubble flag", {31'h0, if_id_interrupt}, 32'd1);
    chk("int bubble pcp1", if_id_pc_plus1, 32'h53);
    chk("int bubble addr", imem_addr, 32'd1);
    tick();
    chk("int vector instr", {16'h0, if_id_instruction}, 32'h5000);
    chk("int vector flag",  {31'h0, if_id_interrupt}, 32'd0);

    // Reset while pending and in IMM_WAIT
    interrupt = 1'b0; branch_taken = 1'b1; branch_target = 32'h60;
    tick();
    branch_taken = 1'b0; interrupt = 1'b1;
    tick();
    chk("pre-rst instr", {16'h0, if_id_instruction}, 32'hA000);
    #2 reset = 1'b0;
    #1;
    chk("async rst valid", {31'h0, if_id_valid}, 32'd0);
    chk("async rst addr",  imem_addr, 32'd0);
    interrupt = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("post-rst instr", {16'h0, if_id_instruction}, 32'h1240);
    chk("post-rst is_imm", {31'h0, if_id_is_imm}, 32'd0);
    tick();
    chk("post-rst no int", {31'h0, if_id_interrupt}, 32'd0);
    chk("post-rst instr2", {16'h0, if_id_instruction}, 32'h5000);
    tick();
    chk("post-rst instr3", {16'h0, if_id_instruction}, 32'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register, sitting directly upstream of the decode stage. It holds the program counter and drives the instruction-memory address. It tags the word that follows an immediate-carrying opcode so decode never interprets it as an instruction. It also redirects on taken branches and injects a marked bubble when it accepts an external interrupt.

## Interface
- PC_WIDTH, 32, program-counter and address width; addresses are 16-bit-word granular.
- RESET_VECTOR, 0, PC value after reset.
- INT_VECTOR, 1, PC loaded when an interrupt is accepted.
- IMM_OPCODE_MASK, 16'h0C00, bit n set means opcode n (instruction[15:12]) is followed by a 16-bit immediate word.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard hold; freezes PC, state and IF/ID outputs.
- branch_taken  in  1  redirect request from a later stage.
- branch_target  in  PC_WIDTH  redirect address.
- interrupt  in  1  external interrupt line; a rising edge raises a request.
- imem_data  in  16  instruction word at imem_addr; combinational, same cycle.
- imem_addr  out  PC_WIDTH  equals PC register.
- if_id_instruction  out  16  latched word.
- if_id_pc_plus1  out  PC_WIDTH  address following the latched word, or the return address for an interrupt bubble.
- if_id_valid  out  1  latched slot holds a real word or an interrupt bubble.
- if_id_is_imm  out  1  latched word is immediate data, not an opcode.
- if_id_interrupt  out  1  latched slot is an interrupt bubble.

## Operation
- State machine with two states.
  - NORMAL: the next fetched word is an opcode.
  - IMM_WAIT: the next fetched word is an immediate.
- Separate flags:
  - int_q: registered copy of interrupt.
  - int_pending: set on interrupt=1 && int_q=0.
- Reset (reset=0, asynchronous):
  - PC=RESET_VECTOR, state=NORMAL, int_q=0, int_pending=0.
  - All if_id_* outputs = 0.
- Per-edge priority, highest first:
  - 1. branch_taken=1:
    - PC<=branch_target.
    - IF/ID<=bubble: instruction=0x0000, valid=0, is_imm=0, interrupt=0, pc_plus1=0.
    - state<=NORMAL.
    - Applies even when stall=1.
  - 2. stall=1: PC, state, int_pending and every if_id_* output hold. int_q still samples, and a rising edge still sets int_pending.
  - 3. int_pending=1 && state=NORMAL:
    - IF/ID<=instruction 0x0000, valid=1, interrupt=1, is_imm=0, pc_plus1=PC (unfetched word = return address).
    - PC<=INT_VECTOR.
    - int_pending cleared, unless a new rising edge occurs on the same edge.
  - 4. Normal fetch:
    - IF/ID<=imem_data, valid=1, interrupt=0, pc_plus1=PC+1.
    - PC<=PC+1.
    - In NORMAL: is_imm=0, and state<=IMM_WAIT if IMM_OPCODE_MASK[imem_data[15:12]]=1.
    - In IMM_WAIT: is_imm=1 and state<=NORMAL. The opcode is not inspected.
- An interrupt is never accepted in IMM_WAIT, so an opcode/immediate pair is never split. int_pending waits in this case.
- Multiple rising edges while int_pending=1 merge into one request.
- PC+1 wraps modulo 2^PC_WIDTH without a flag.

## Timing
- imem_addr is valid for the whole cycle. imem_data is consumed at the end of that cycle.
- A fetched word appears on the if_id_* outputs one edge after its address is presented.
- Branch: on the edge where branch_taken=1, IF/ID holds a bubble. The target word appears on the following edge. Branch penalty is one bubble from this stage.
- Interrupt: interrupt rises before edge E. int_pending is set at E. The bubble appears at E+1 at the earliest, later while in IMM_WAIT or stalled. The INT_VECTOR word appears at E+2.
- Reset asserted mid-operation forces reset values immediately. The first fetch after deassertion uses RESET_VECTOR.

## Test plan
- Reset then release: reset=0 → all if_id_*=0 and imem_addr=0. After release with imem returning 0x1240, 0x5000: outputs 0x1240/pc_plus1=1, then 0x5000/pc_plus1=2, valid=1.
- Immediate pair: mem[0]=0xA200, mem[1]=0xA200 → cycle 1: is_imm=0; cycle 2: instruction=0xA200 with is_imm=1 (not re-decoded); state returns to NORMAL.
- Stall: stall=1 for 3 cycles at PC=5 → imem_addr stays 5, outputs unchanged. Release → fetch resumes at 5 with no word lost or duplicated.
- Branch with stall: branch_taken=1, target=0x40, stall=1 → bubble (valid=0), PC=0x40. Next edge: mem[0x40] word with pc_plus1=0x41. Repeat with branch taken while in IMM_WAIT → next word has is_imm=0.
- Interrupt deferral: interrupt rises on the cycle the 0xA… opcode is fetched → immediate latched first. Then a bubble with if_id_interrupt=1, pc_plus1=address after immediate. Then the INT_VECTOR word.
- Reset mid-stream: reset=0 asynchronously while int_pending=1 and in IMM_WAIT → pending cleared, state=NORMAL, no interrupt bubble after release.
